// File: rtl/debug_ctrl_if.sv
// -----------------------------------------------------------------------------
// debug_ctrl_if
// Purpose : core-side debug handshake between debug_ctrl (master) and the hart
//           debug logic (slave).
// Signals :
//   dbg_halt_req    master->slave  request the hart to halt
//   dbg_resume_req  master->slave  request the hart to resume
//   dbg_exec        master->slave  one-cycle command strobe
//   dbg_command     master->slave  latched abstract command
//   dbg_data0/1     master->slave  data register contents
//   dbg_halted      slave->master  hart is halted
//   dbg_done        slave->master  command/halt-resume completion strobe
//   dbg_write       slave->master  dbg_data0_out is valid for write-back
//   dbg_bus         slave->master  exception was a bus error
//   dbg_haltresume  slave->master  done refers to halt/resume, not a command
//   dbg_exception   slave->master  command raised an exception
//   dbg_data0_out   slave->master  write-back data for data0
// -----------------------------------------------------------------------------
interface debug_ctrl_if;
    logic        dbg_halt_req;
    logic        dbg_resume_req;
    logic        dbg_exec;
    logic [31:0] dbg_command;
    logic [31:0] dbg_data0;
    logic [31:0] dbg_data1;
    logic        dbg_halted;
    logic        dbg_done;
    logic        dbg_write;
    logic        dbg_bus;
    logic        dbg_haltresume;
    logic        dbg_exception;
    logic [31:0] dbg_data0_out;

    modport master (
        output dbg_halt_req, dbg_resume_req, dbg_exec,
        output dbg_command, dbg_data0, dbg_data1,
        input  dbg_halted, dbg_done, dbg_write, dbg_bus,
        input  dbg_haltresume, dbg_exception, dbg_data0_out
    );

    modport slave (
        input  dbg_halt_req, dbg_resume_req, dbg_exec,
        input  dbg_command, dbg_data0, dbg_data1,
        output dbg_halted, dbg_done, dbg_write, dbg_bus,
        output dbg_haltresume, dbg_exception, dbg_data0_out
    );
endinterface

// File: rtl/debug_ctrl.sv
// -----------------------------------------------------------------------------
// debug_ctrl
// Purpose : debug-module side controller. Forwards halt/resume requests to the
//           hart, reports hart status, and runs one abstract command at a time
//           through an IDLE -> EXEC -> WAIT command FSM with a sticky cmderr.
// Ports   :
//   clk, rst                 clock, synchronous active-high reset
//   haltreq_i / resumereq_i  level halt request / one-cycle resume pulse
//   cmd_we, cmd_wdata        command register write
//   dataN_we, dataN_wdata    data register writes (N = 0, 1)
//   cmderr_clr               write-1-to-clear mask for cmderr
//   data0_o, data1_o         data registers
//   busy                     command in flight
//   cmderr                   sticky error code
//   allhalted/allrunning     registered hart status
//   resumeack                hart has resumed since the last accepted resume
//   dbg                      core-side handshake (debug_ctrl_if.master)
// Build option: define DEBUG_CTRL_TIMEOUT_EN to abort WAIT after
//   TIMEOUT_CYCLES cycles with cmderr = 7.
// -----------------------------------------------------------------------------
module debug_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                haltreq_i,
    input  logic                resumereq_i,
    input  logic                cmd_we,
    input  logic [31:0]         cmd_wdata,
    input  logic                data0_we,
    input  logic                data1_we,
    input  logic [31:0]         data0_wdata,
    input  logic [31:0]         data1_wdata,
    input  logic [2:0]          cmderr_clr,
    output logic [31:0]         data0_o,
    output logic [31:0]         data1_o,
    output logic                busy,
    output logic [2:0]          cmderr,
    output logic                allhalted,
    output logic                allrunning,
    output logic                resumeack,
    debug_ctrl_if.master        dbg
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT} state_t;

    state_t      r_state, w_next;
    logic        r_halt_req, r_pend, r_ack, r_allh, r_allr;
    logic [31:0] r_data0, r_data1, r_cmd;
    logic [2:0]  r_cmderr, w_err_code;
    logic        w_res_acc, w_accept, w_done_ok, w_timeout;

    // Resume only when halted and not simultaneously asked to halt.
    assign w_res_acc = resumereq_i & dbg.dbg_halted & ~haltreq_i;
    assign w_accept  = (r_state == S_IDLE) & cmd_we & (r_cmderr == 3'd0) &
                       (cmd_wdata[31:24] == 8'd0) & dbg.dbg_halted & ~r_pend;
    // Halt/resume completions share dbg_done and must not end a command.
    assign w_done_ok = (r_state == S_WAIT) & dbg.dbg_done & ~dbg.dbg_haltresume;

`ifdef DEBUG_CTRL_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    assign w_timeout = (r_state == S_WAIT) & ~w_done_ok &
                       (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || r_state != S_WAIT) r_tmo_cnt <= 16'd0;
        else                          r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_EXEC;
            S_EXEC:  w_next = S_WAIT;
            S_WAIT:  if (w_done_ok || w_timeout) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Candidate error for this cycle; only recorded when cmderr is clear.
    always_comb begin
        w_err_code = 3'd0;
        if (r_state != S_IDLE && (cmd_we || data0_we || data1_we))
            w_err_code = 3'd1;
        else if (r_state == S_IDLE && cmd_we && cmd_wdata[31:24] != 8'd0)
            w_err_code = 3'd2;
        else if (r_state == S_IDLE && cmd_we && (!dbg.dbg_halted || r_pend))
            w_err_code = 3'd4;
        else if (w_done_ok && dbg.dbg_exception)
            w_err_code = dbg.dbg_bus ? 3'd5 : 3'd3;
        else if (w_timeout)
            w_err_code = 3'd7;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_halt_req <= 1'b0;
            r_pend     <= 1'b0;
            r_ack      <= 1'b0;
            r_allh     <= 1'b0;
            r_allr     <= ~dbg.dbg_halted;
            r_cmderr   <= 3'd0;
            r_cmd      <= 32'd0;
            r_data0    <= 32'd0;
            r_data1    <= 32'd0;
        end else begin
            r_halt_req <= haltreq_i & ~dbg.dbg_halted;
            r_allh     <= dbg.dbg_halted;
            r_allr     <= ~dbg.dbg_halted;

            if (w_res_acc) begin
                r_pend <= 1'b1;
                r_ack  <= 1'b0;
            end else if (r_pend && !dbg.dbg_halted) begin
                r_pend <= 1'b0;
                r_ack  <= 1'b1;
            end

            if (r_cmderr == 3'd0 && w_err_code != 3'd0) r_cmderr <= w_err_code;
            else                                       r_cmderr <= r_cmderr & ~cmderr_clr;

            if (w_accept) r_cmd <= cmd_wdata;

            if (r_state == S_IDLE && data0_we)
                r_data0 <= data0_wdata;
            else if (w_done_ok && !dbg.dbg_exception && dbg.dbg_write)
                r_data0 <= dbg.dbg_data0_out;

            if (r_state == S_IDLE && data1_we) r_data1 <= data1_wdata;
        end
    end

    assign dbg.dbg_halt_req   = r_halt_req;
    assign dbg.dbg_resume_req = r_pend;
    assign dbg.dbg_exec       = (r_state == S_EXEC);
    assign dbg.dbg_command    = r_cmd;
    assign dbg.dbg_data0      = r_data0;
    assign dbg.dbg_data1      = r_data1;
    assign busy               = (r_state != S_IDLE);
    assign cmderr             = r_cmderr;
    assign data0_o            = r_data0;
    assign data1_o            = r_data1;
    assign allhalted          = r_allh;
    assign allrunning         = r_allr;
    assign resumeack          = r_ack;
endmodule

// File: tb/tb_debug_ctrl.sv
// -----------------------------------------------------------------------------
// tb_debug_ctrl
// Purpose : directed + randomized bench for debug_ctrl against a behavioural
//           model of the debug controller rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_debug_ctrl;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        haltreq_i, resumereq_i, cmd_we, data0_we, data1_we;
    logic [31:0] cmd_wdata, data0_wdata, data1_wdata;
    logic [2:0]  cmderr_clr;
    logic [31:0] data0_o, data1_o;
    logic        busy, allhalted, allrunning, resumeack;
    logic [2:0]  cmderr;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: phase 0 = no command, 1 = strobe cycle, 2 = awaiting core
    bit          m_halt_req, m_pend, m_ack, m_allh, m_allr;
    int          m_phase, m_wait_cycles;
    bit [2:0]    m_err;
    bit [31:0]   m_d0, m_d1, m_cmd;

    int cnt_exec, cnt_busy, cnt_hreq, cnt_rreq;

    always #5 clk = ~clk;

    debug_ctrl_if dif ();

    debug_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .haltreq_i   (haltreq_i),
        .resumereq_i (resumereq_i),
        .cmd_we      (cmd_we),
        .cmd_wdata   (cmd_wdata),
        .data0_we    (data0_we),
        .data1_we    (data1_we),
        .data0_wdata (data0_wdata),
        .data1_wdata (data1_wdata),
        .cmderr_clr  (cmderr_clr),
        .data0_o     (data0_o),
        .data1_o     (data1_o),
        .busy        (busy),
        .cmderr      (cmderr),
        .allhalted   (allhalted),
        .allrunning  (allrunning),
        .resumeack   (resumeack),
        .dbg         (dif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit       halted, done_q, tmo_hit, accept;
        bit [2:0] err_new;
        halted = dif.dbg_halted;
        if (rst) begin
            m_halt_req = 0; m_pend = 0; m_ack = 0; m_allh = 0; m_allr = !halted;
            m_phase = 0; m_wait_cycles = 0; m_err = 0; m_d0 = 0; m_d1 = 0; m_cmd = 0;
            return;
        end
        done_q  = (m_phase == 2) && dif.dbg_done && !dif.dbg_haltresume;
        tmo_hit = 0;
`ifdef DEBUG_CTRL_TIMEOUT_EN
        tmo_hit = (m_phase == 2) && !done_q && (m_wait_cycles + 1 == TMO);
`endif
        accept = (m_phase == 0) && cmd_we && (m_err == 0) && (cmd_wdata[31:24] == 0)
                 && halted && !m_pend;

        err_new = 0;
        if (m_phase != 0 && (cmd_we || data0_we || data1_we))        err_new = 1;
        else if (m_phase == 0 && cmd_we && cmd_wdata[31:24] != 0)     err_new = 2;
        else if (m_phase == 0 && cmd_we && (!halted || m_pend))       err_new = 4;
        else if (done_q && dif.dbg_exception)                         err_new = dif.dbg_bus ? 5 : 3;
        else if (tmo_hit)                                             err_new = 7;
        if (m_err == 0 && err_new != 0) m_err = err_new;
        else                            m_err = m_err & ~cmderr_clr;

        if (m_phase == 0 && data0_we) m_d0 = data0_wdata;
        else if (done_q && !dif.dbg_exception && dif.dbg_write) m_d0 = dif.dbg_data0_out;
        if (m_phase == 0 && data1_we) m_d1 = data1_wdata;
        if (accept) m_cmd = cmd_wdata;

        if (resumereq_i && halted && !haltreq_i) begin m_pend = 1; m_ack = 0; end
        else if (m_pend && !halted)              begin m_pend = 0; m_ack = 1; end

        m_halt_req = haltreq_i && !halted;
        m_allh = halted;
        m_allr = !halted;

        if (m_phase == 0)      begin if (accept) m_phase = 1; end
        else if (m_phase == 1) begin m_phase = 2; m_wait_cycles = 0; end
        else if (done_q || tmo_hit) m_phase = 0;
        else m_wait_cycles++;
    endtask

    task automatic check_all();
        chk("dbg_halt_req",   dif.dbg_halt_req,   m_halt_req);
        chk("dbg_resume_req", dif.dbg_resume_req, m_pend);
        chk("dbg_exec",       dif.dbg_exec,       m_phase == 1);
        chk("busy",           busy,               m_phase != 0);
        chk("cmderr",         cmderr,             m_err);
        chk("allhalted",      allhalted,          m_allh);
        chk("allrunning",     allrunning,         m_allr);
        chk("resumeack",      resumeack,          m_ack);
        chk("data0_o",        data0_o,            m_d0);
        chk("data1_o",        data1_o,            m_d1);
        chk("dbg_command",    dif.dbg_command,    m_cmd);
        chk("dbg_data0",      dif.dbg_data0,      m_d0);
        chk("dbg_data1",      dif.dbg_data1,      m_d1);
    endtask

    // One clock: model and DUT see the same inputs, outputs sampled 1ns later,
    // then one-cycle pulse inputs are dropped.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_all();
        if (dif.dbg_exec)       cnt_exec++;
        if (busy)               cnt_busy++;
        if (dif.dbg_halt_req)   cnt_hreq++;
        if (dif.dbg_resume_req) cnt_rreq++;
        resumereq_i = 0; cmd_we = 0; data0_we = 0; data1_we = 0;
        cmderr_clr = 0; dif.dbg_done = 0;
    endtask

    task automatic issue_cmd(input logic [31:0] c);
        cmd_we = 1; cmd_wdata = c;
        step();
    endtask

    initial begin
        rst = 1; haltreq_i = 0; resumereq_i = 0; cmd_we = 0; cmd_wdata = 0;
        data0_we = 0; data1_we = 0; data0_wdata = 0; data1_wdata = 0; cmderr_clr = 0;
        dif.dbg_halted = 0; dif.dbg_done = 0; dif.dbg_write = 0; dif.dbg_bus = 0;
        dif.dbg_haltresume = 0; dif.dbg_exception = 0; dif.dbg_data0_out = 0;

        // Reset state
        step(); step();
        chk("reset_allrunning", allrunning, 1'b1);
        rst = 0;
        step();

        // Halt: core halts after 3 cycles of request
        cnt_hreq = 0;
        haltreq_i = 1;
        step(); step(); step();
        dif.dbg_halted = 1;
        step(); step(); step();
        chk("halt_req_cycles", cnt_hreq, 3);
        chk("halted_status", allhalted, 1'b1);
        haltreq_i = 0;
        step();

        // Resume: core drops halted after 2 cycles
        cnt_rreq = 0;
        resumereq_i = 1;
        step(); step();
        dif.dbg_halted = 0;
        step(); step();
        chk("resume_req_cycles", cnt_rreq, 2);
        chk("resumeack_set", resumeack, 1'b1);

        // Re-halt for commands; preload data registers
        haltreq_i = 1; step(); dif.dbg_halted = 1; step(); haltreq_i = 0; step();
        data0_we = 1; data0_wdata = 32'h1234_5678; data1_we = 1; data1_wdata = 32'hA5A5_0F0F;
        step();

        // Good command with write-back
        cnt_exec = 0; cnt_busy = 0;
        issue_cmd(32'h0022_1000);
        step(); step(); step(); step();
        dif.dbg_done = 1; dif.dbg_write = 1; dif.dbg_data0_out = 32'hDEAD_BEEF;
        step(); step();
        chk("cmd_exec_cycles", cnt_exec, 1);
        chk("cmd_busy_cycles", cnt_busy, 5);
        chk("cmd_data0", data0_o, 32'hDEAD_BEEF);
        chk("cmd_cmderr", cmderr, 3'd0);

        // cmd_we while busy -> 1
        issue_cmd(32'h0000_0001);
        issue_cmd(32'h0000_0002);
        dif.dbg_done = 1; dif.dbg_write = 0; step();
        chk("err_busy", cmderr, 3'd1);
        // clear, then bad cmdtype -> 2
        cmderr_clr = 3'b111; step();
        issue_cmd(32'h0100_0000);
        chk("err_cmdtype", cmderr, 3'd2);
        // clear, then command while running -> 4, no exec
        cmderr_clr = 3'b111; step();
        dif.dbg_halted = 0; step();
        cnt_exec = 0;
        issue_cmd(32'h0000_0003); step();
        chk("err_running", cmderr, 3'd4);
        chk("err_running_noexec", cnt_exec, 0);
        cmderr_clr = 3'b111; haltreq_i = 1; step(); dif.dbg_halted = 1; step(); haltreq_i = 0; step();

        // haltresume done ignored, then exception+bus done -> 5, data0 kept
        issue_cmd(32'h0000_0004); step();
        dif.dbg_done = 1; dif.dbg_haltresume = 1; step();
        chk("haltresume_ignored", busy, 1'b1);
        dif.dbg_haltresume = 0;
        dif.dbg_done = 1; dif.dbg_exception = 1; dif.dbg_bus = 1; dif.dbg_write = 1;
        dif.dbg_data0_out = 32'h0BAD_0BAD; step();
        chk("exc_bus_err", cmderr, 3'd5);
        chk("exc_data0_kept", data0_o, 32'hDEAD_BEEF);
        dif.dbg_exception = 0; dif.dbg_bus = 0;
        cmderr_clr = 3'b111; step();

        // Reset mid-WAIT abandons the command; later done ignored
        issue_cmd(32'h0000_0005); step(); step();
        rst = 1; step(); rst = 0;
        chk("rst_busy", busy, 1'b0);
        dif.dbg_done = 1; dif.dbg_write = 1; dif.dbg_data0_out = 32'hFFFF_0000; step();
        chk("rst_data0", data0_o, 32'h0);

`ifdef DEBUG_CTRL_TIMEOUT_EN
        haltreq_i = 1; step(); haltreq_i = 0; step();
        cnt_busy = 0;
        issue_cmd(32'h0000_0006);
        for (int i = 0; i < 12; i++) step();
        chk("tmo_busy_cycles", cnt_busy, TMO + 1);
        chk("tmo_cmderr", cmderr, 3'd7);
        cmderr_clr = 3'b111; step();
        issue_cmd(32'h0000_0007); step(); step(); step();
        rst = 1; step(); rst = 0;
        chk("tmo_rst_busy", busy, 1'b0);
        chk("tmo_rst_cmderr", cmderr, 3'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) haltreq_i = ~haltreq_i;
            if ($urandom_range(0, 19) == 0) dif.dbg_halted = ~dif.dbg_halted;
            resumereq_i = ($urandom_range(0, 9) == 0);
            cmd_we      = ($urandom_range(0, 6) == 0);
            cmd_wdata   = $urandom;
            if ($urandom_range(0, 4) != 0) cmd_wdata[31:24] = 8'd0;
            data0_we    = ($urandom_range(0, 9) == 0);
            data1_we    = ($urandom_range(0, 9) == 0);
            data0_wdata = $urandom;
            data1_wdata = $urandom;
            cmderr_clr  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd0;
            dif.dbg_done       = ($urandom_range(0, 3) == 0);
            dif.dbg_haltresume = ($urandom_range(0, 2) == 0);
            dif.dbg_exception  = ($urandom_range(0, 4) == 0);
            dif.dbg_bus        = 1'($urandom);
            dif.dbg_write      = 1'($urandom);
            dif.dbg_data0_out  = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
